alu6_module: RTL and testbench

//  - Registered WIDTH-bit (default 6) two's-complement ALU: operands x, y; opcode fxn.
//  - Returns a result, a carry flag and a signed-overflow flag one clock after the inputs are sampled.
//  - Standalone arithmetic leaf; used as the datapath core of small processor/lab designs.

---
 rtl/alu6_module.sv | 138 +++++++++++++
 tb/tb_alu6_module.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu6_module.sv
// alu6_module: registered WIDTH-bit two's-complement ALU.
// Result, carry and signed-overflow are computed combinationally from
// x, y and fxn and registered once at posedge clk (one-cycle latency).
// Optional macro ALU_EXT_OPS_EN enables the extended bank (fxn[3]=1);
// without it fxn[3] is ignored and fxn[2:0] selects the base bank.
module alu6_module #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       fxn,
  output logic [WIDTH-1:0] answer,
  output logic             carry,
  output logic             o_flow
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [3:0]       op;
  logic [WIDTH:0]   neg_x_w;
  logic [WIDTH:0]   neg_y_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   add_w;
  logic             sub_ovf;
  logic             add_ovf;
  logic             slt;
  logic             ult;

  logic [WIDTH-1:0] answer_d, answer_q;
  logic             carry_d, carry_q;
  logic             oflow_d, oflow_q;

`ifdef ALU_EXT_OPS_EN
  assign op = fxn;
`else
  // Extended bank absent: force the bank-select bit low.
  assign op = fxn & 4'b0111;
`endif

  // Shared adders; the extra top bit is the carry-out of the MSB.
  assign neg_x_w = {1'b0, ~x} + ONE_W;
  assign neg_y_w = {1'b0, ~y} + ONE_W;
  assign sub_w   = {1'b0, x} + {1'b0, ~y} + ONE_W;
  assign add_w   = {1'b0, x} + {1'b0, y};

  assign sub_ovf = (x[MSB] ^ y[MSB]) & (sub_w[MSB] ^ x[MSB]);
  assign add_ovf = ~(x[MSB] ^ y[MSB]) & (add_w[MSB] ^ x[MSB]);

  // Signed compare uses sign XOR overflow so wraparound cannot mislead it.
  assign slt = sub_w[MSB] ^ sub_ovf;
  // Carry-out of x-y is "no borrow", so unsigned x<y is its inverse.
  assign ult = ~sub_w[WIDTH];

  // Next-state decode of result and flags.
  always_comb begin
    answer_d = '0;
    carry_d  = 1'b0;
    oflow_d  = 1'b0;
    case (op)
      4'b0000: answer_d = x;
      4'b0001: answer_d = y;
      4'b0010: begin
        answer_d = neg_x_w[MSB:0];
        carry_d  = neg_x_w[WIDTH];
        oflow_d  = (x == MIN_V);
      end
      4'b0011: begin
        answer_d = neg_y_w[MSB:0];
        carry_d  = neg_y_w[WIDTH];
        oflow_d  = (y == MIN_V);
      end
      4'b0100: begin
        answer_d = sub_w[MSB:0];
        carry_d  = sub_w[WIDTH];
        oflow_d  = sub_ovf;
      end
      4'b0101: begin
        answer_d = add_w[MSB:0];
        carry_d  = add_w[WIDTH];
        oflow_d  = add_ovf;
      end
      4'b0110: answer_d = x ^ y;
      4'b0111: begin
        answer_d = {{(WIDTH-1){1'b0}}, slt};
        carry_d  = ult;
      end
`ifdef ALU_EXT_OPS_EN
      4'b1000: answer_d = x & y;
      4'b1001: answer_d = x | y;
      4'b1010: answer_d = ~x;
      4'b1011: begin
        answer_d = {x[MSB-1:0], 1'b0};
        carry_d  = x[MSB];
      end
      4'b1100: begin
        answer_d = {1'b0, x[MSB:1]};
        carry_d  = x[0];
      end
      4'b1101: begin
        answer_d = {x[MSB], x[MSB:1]};
        carry_d  = x[0];
      end
      4'b1110: begin
        answer_d = {x[MSB-1:0], x[MSB]};
        carry_d  = x[MSB];
      end
      4'b1111: answer_d = {{(WIDTH-1){1'b0}}, (~slt & (x != y))};
`endif
      default: begin
        answer_d = '0;
        carry_d  = 1'b0;
        oflow_d  = 1'b0;
      end
    endcase
  end

  // Output register; reset clears any pending result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      answer_q <= '0;
      carry_q  <= 1'b0;
      oflow_q  <= 1'b0;
    end else begin
      answer_q <= answer_d;
      carry_q  <= carry_d;
      oflow_q  <= oflow_d;
    end
  end

  assign answer = answer_q;
  assign carry  = carry_q;
  assign o_flow = oflow_q;

endmodule

// File: tb/tb_alu6_module.sv
// Self-checking bench for alu6_module (WIDTH=6).
// Expected {answer, carry, o_flow} comes from an integer-arithmetic model,
// is queued when inputs are driven and popped one clock later.
module tb_alu6_module;

  localparam int W   = 6;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [3:0]   fxn;
  logic [W-1:0] answer;
  logic         carry;
  logic         o_flow;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_out;
  int           total;
  int           bad;

  alu6_module #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .fxn    (fxn),
    .answer (answer),
    .carry  (carry),
    .o_flow (o_flow)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got ans=%b c=%b v=%b want ans=%b c=%b v=%b", tag,
               obs[W+1:2], obs[1], obs[0], expv[W+1:2], expv[1], expv[0]);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - MOD : int'(v);
  endfunction

  // Reference model written from the arithmetic definitions.
  function automatic logic [W+1:0] model(input logic [3:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [W-1:0] ans;
    ua = int'(a); ub = int'(b); sa = sval(a); sb = sval(b);
    r = 0; c = 1'b0; v = 1'b0;
`ifdef ALU_EXT_OPS_EN
    if (f[3]) begin
      case (f[2:0])
        3'd0: r = ua & ub;
        3'd1: r = ua | ub;
        3'd2: r = (MOD - 1) - ua;
        3'd3: begin r = (ua * 2) % MOD; c = (ua >= MOD / 2); end
        3'd4: begin r = ua / 2; c = ua[0]; end
        3'd5: begin r = (sa < 0) ? (ua / 2 + MOD / 2) : ua / 2; c = ua[0]; end
        3'd6: begin r = (ua * 2) % MOD + ((ua >= MOD / 2) ? 1 : 0); c = (ua >= MOD / 2); end
        default: r = (sa > sb) ? 1 : 0;
      endcase
    end else
`endif
    begin
      case (f[2:0])
        3'd0: r = ua;
        3'd1: r = ub;
        3'd2: begin r = (MOD - ua) % MOD; c = (ua == 0); v = (sa == -(MOD / 2)); end
        3'd3: begin r = (MOD - ub) % MOD; c = (ub == 0); v = (sb == -(MOD / 2)); end
        3'd4: begin
          r = (ua - ub + MOD) % MOD; c = (ua >= ub);
          s = sa - sb; v = (s > MOD / 2 - 1) || (s < -(MOD / 2));
        end
        3'd5: begin
          r = (ua + ub) % MOD; c = (ua + ub >= MOD);
          s = sa + sb; v = (s > MOD / 2 - 1) || (s < -(MOD / 2));
        end
        3'd6: r = ua ^ ub;
        default: begin r = (sa < sb) ? 1 : 0; c = (ua < ub); end
      endcase
    end
    ans = W'(r);
    return {ans, c, v};
  endfunction

  // One cycle: compare the result of the previous drive, then drive new
  // inputs and confirm the outputs do not move before the next edge.
  task automatic step(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    logic [W+1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {answer, carry, o_flow}, e);
      last_out = e;
    end
    fxn = f; x = a; y = b;
    exp_q.push_back(model(f, a, b));
    #1;
    check("hold_before_edge", {answer, carry, o_flow}, last_out);
  endtask

  // Asynchronous reset between clock edges, holding it across one edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {answer, carry, o_flow}, '0);
    exp_q.delete();
    last_out = '0;
    fxn = 4'd0; x = '0; y = '0;
    @(posedge clk);
    #1;
    check("reset_held", {answer, carry, o_flow}, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    last_out = '0;
    rst = 1'b1; fxn = 4'd0; x = '0; y = '0;
    #1;
    check("reset_state", {answer, carry, o_flow}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    step("pass_a",     4'b0000, 6'b111111, 6'b000000);
    step("pass_b",     4'b0001, 6'b111111, 6'b000000);
    step("neg_zero",   4'b0010, 6'b000000, 6'b010101);
    step("neg_min",    4'b0010, 6'b100000, 6'b000000);
    step("neg_y",      4'b0011, 6'b000000, 6'b100000);
    step("sub_nb",     4'b0100, 6'b111111, 6'b011111);
    step("sub_ovf",    4'b0100, 6'b000000, 6'b100000);
    step("add_ovf",    4'b0101, 6'b010111, 6'b011110);
    step("add_carry",  4'b0101, 6'b111111, 6'b000001);
    step("xor",        4'b0110, 6'b010101, 6'b101010);
    step("pass_a2",    4'b0000, 6'b111111, 6'b000000);
    step("slt_mixed",  4'b0111, 6'b111111, 6'b011111);
    step("slt_wrap",   4'b0111, 6'b011111, 6'b100000);
    step("slt_eq",     4'b0111, 6'b100000, 6'b100000);
    step("add_neg",    4'b0101, 6'b100000, 6'b100000);

    // Reset while a result is pending
    step("pre_reset",  4'b0101, 6'b000111, 6'b000001);
    async_reset();

    // Random stimulus over the full opcode field
    for (int i = 0; i < 300; i++) begin
      step("random", 4'($urandom_range(0, 15)), W'($urandom_range(0, MOD - 1)),
           W'($urandom_range(0, MOD - 1)));
    end
    step("drain", 4'b0000, 6'b000000, 6'b000000);
    @(negedge clk);
    if (exp_q.size() > 0) check("drain_last", {answer, carry, o_flow}, exp_q.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
